// File: rtl/ahb5_to_apb_bridge_if.sv
// ahb5_to_apb_bridge_if: AHB5 slave side and APB master side of the bridge.
//   slave  modport: the bridge's view (AHB inputs in, AHB responses out,
//                   APB requests out, APB responses in).
//   master modport: the view of the environment driving the bridge.
//   PADDR_W: APB address width (must match the bridge's PADDR_W).
interface ahb5_to_apb_bridge_if #(
    parameter int unsigned PADDR_W = 32
);
    // AHB side
    logic               HSEL;
    logic [31:0]        HADDR;
    logic               HWRITE;
    logic [1:0]         HTRANS;
    logic [2:0]         HSIZE;
    logic [31:0]        HWDATA;
    logic               HREADY;
    logic               HREADYOUT;
    logic [31:0]        HRDATA;
    logic               HRESP;
    // APB side
    logic [PADDR_W-1:0] PADDR;
    logic [31:0]        PWDATA;
    logic               PWRITE;
    logic [3:0]         PSTRB;
    logic               PSEL;
    logic               PENABLE;
    logic [31:0]        PRDATA;
    logic               PREADY;
    logic               PSLVERR;

    modport slave (
        input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRDATA, HRESP,
        output PADDR, PWDATA, PWRITE, PSTRB, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport master (
        output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA, HRESP,
        input  PADDR, PWDATA, PWRITE, PSTRB, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/ahb5_to_apb_bridge.sv
// ahb5_to_apb_bridge: converts single AHB5 transfers into APB transfers.
// Each accepted AHB transfer walks LATCH -> SETUP -> ACCESS and completes
// with a minimum of three wait states; all outputs are registered.
//   HCLK    : clock, rising edge
//   HRESET  : asynchronous active-high reset
//   bus     : ahb5_to_apb_bridge_if.slave (AHB slave + APB master signals)
//   PADDR_W : APB address width, PADDR = HADDR[PADDR_W-1:0]
// Build option: define AHB2APB_ERR_RESP_EN to turn PSLVERR into a two-cycle
// AHB ERROR response (ERR1/ERR2); otherwise PSLVERR is ignored, HRESP = 0.
module ahb5_to_apb_bridge #(
    parameter int unsigned PADDR_W = 32
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    ahb5_to_apb_bridge_if.slave    bus
);

`ifdef AHB2APB_ERR_RESP_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3
    } state_t;
`endif

    state_t             state_q, state_d;
    logic               hreadyout_q, hreadyout_d;
    logic               hresp_q, hresp_d;
    logic [31:0]        hrdata_q, hrdata_d;
    logic [PADDR_W-1:0] paddr_q, paddr_d;
    logic [31:0]        pwdata_q, pwdata_d;
    logic               pwrite_q, pwrite_d;
    logic [3:0]         pstrb_q, pstrb_d;
    logic               psel_q, psel_d;
    logic               penable_q, penable_d;
    logic               accept_c;

    // Byte-lane strobe for a write of the given size at the given address.
    function automatic logic [3:0] write_strobe(input logic [2:0] size,
                                                input logic [1:0] addr);
        logic [3:0] strb;
        if (size == 3'd0) begin
            strb = 4'(4'b0001 << addr);
        end else if (size == 3'd1) begin
            strb = addr[1] ? 4'b1100 : 4'b0011;
        end else begin
            strb = 4'b1111;
        end
        return strb;
    endfunction

    // NONSEQ and SEQ are the only HTRANS codes with bit 1 set.
    assign accept_c = bus.HSEL && bus.HREADY && bus.HTRANS[1];

    // Unused inputs gathered here so the intent is explicit.
`ifdef AHB2APB_ERR_RESP_EN
    logic unused_c;
    assign unused_c = bus.HTRANS[0];
`else
    logic unused_c;
    assign unused_c = ^{bus.HTRANS[0], bus.PSLVERR};
`endif

    // State and output registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= 32'd0;
            paddr_q     <= '0;
            pwdata_q    <= 32'd0;
            pwrite_q    <= 1'b0;
            pstrb_q     <= 4'd0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            pstrb_q     <= pstrb_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
        end
    end

    // Next state and next registered outputs (values seen in the next state).
    always_comb begin
        state_d     = state_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        hrdata_d    = hrdata_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        pstrb_d     = pstrb_q;
        psel_d      = psel_q;
        penable_d   = penable_q;

        case (state_q)
            ST_IDLE: begin
                hreadyout_d = 1'b1;
                hresp_d     = 1'b0;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                if (accept_c) begin
                    // Address-phase capture goes straight into the APB registers.
                    state_d     = ST_LATCH;
                    hreadyout_d = 1'b0;
                    paddr_d     = bus.HADDR[PADDR_W-1:0];
                    pwrite_d    = bus.HWRITE;
                    pstrb_d     = bus.HWRITE ? write_strobe(bus.HSIZE, bus.HADDR[1:0])
                                             : 4'b0000;
                end
            end
            ST_LATCH: begin
                // HWDATA is only valid in the AHB data phase, i.e. this cycle.
                state_d = ST_SETUP;
                psel_d  = 1'b1;
                if (pwrite_q) begin
                    pwdata_d = bus.HWDATA;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                if (bus.PREADY) begin
                    state_d     = ST_IDLE;
                    hreadyout_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    if (!pwrite_q) begin
                        hrdata_d = bus.PRDATA;
                    end
`ifdef AHB2APB_ERR_RESP_EN
                    if (bus.PSLVERR) begin
                        state_d     = ST_ERR1;
                        hreadyout_d = 1'b0;
                        hresp_d     = 1'b1;
                        hrdata_d    = hrdata_q;
                    end
`endif
                end
            end
`ifdef AHB2APB_ERR_RESP_EN
            ST_ERR1: begin
                state_d     = ST_ERR2;
                hreadyout_d = 1'b1;
                hresp_d     = 1'b1;
            end
            ST_ERR2: begin
                // Any transfer offered here is deliberately dropped.
                state_d     = ST_IDLE;
                hreadyout_d = 1'b1;
                hresp_d     = 1'b0;
            end
`endif
            default: begin
                state_d     = ST_IDLE;
                hreadyout_d = 1'b1;
                hresp_d     = 1'b0;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
            end
        endcase
    end

    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
    assign bus.HRDATA    = hrdata_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PSTRB     = pstrb_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;

endmodule

// File: tb/tb_ahb5_to_apb_bridge.sv
// tb_ahb5_to_apb_bridge: directed + randomized checks of ahb5_to_apb_bridge
// against a transaction-level model (cycle offsets from the accept edge,
// arithmetic strobe computation, last-read-data tracking).
module tb_ahb5_to_apb_bridge;

    logic HCLK;
    logic HRESET;
    int   n_checks;
    int   n_fail;
    logic [31:0] exp_hrdata;

    ahb5_to_apb_bridge_if #(.PADDR_W(32)) bus ();

    ahb5_to_apb_bridge #(.PADDR_W(32)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Lane mask from transfer size in bytes: mask width = bytes, aligned down.
    function automatic logic [3:0] model_strobe(input logic wr, input logic [2:0] size,
                                                input logic [1:0] addr);
        int nbytes;
        int lane;
        if (!wr) return 4'h0;
        nbytes = (size >= 3'd2) ? 4 : (1 << size);
        lane   = int'(addr) & (4 - nbytes);
        return 4'(((1 << nbytes) - 1) << lane);
    endfunction

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_hreadyout"}, 32'(bus.HREADYOUT), 32'd1);
        check_eq({tag, "_hresp"},     32'(bus.HRESP),     32'd0);
        check_eq({tag, "_hrdata"},    bus.HRDATA,         32'd0);
        check_eq({tag, "_paddr"},     bus.PADDR,          32'd0);
        check_eq({tag, "_pwdata"},    bus.PWDATA,         32'd0);
        check_eq({tag, "_pwrite"},    32'(bus.PWRITE),    32'd0);
        check_eq({tag, "_pstrb"},     32'(bus.PSTRB),     32'd0);
        check_eq({tag, "_psel"},      32'(bus.PSEL),      32'd0);
        check_eq({tag, "_penable"},   32'(bus.PENABLE),   32'd0);
    endtask

    // Data-phase AHB activity: other masters' noise, HREADY low as the bus would be.
    task automatic drive_ahb_noise();
        bus.HSEL   = 1'($urandom);
        bus.HTRANS = 2'($urandom);
        bus.HREADY = 1'b0;
        bus.HADDR  = $urandom;
    endtask

    task automatic clear_ahb();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HREADY = 1'b1;
    endtask

    // Entered and left at a negedge where the bridge shows HREADYOUT=1.
    task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] wdata, input int waits,
                            input logic [31:0] rdata, input logic slverr);
        logic [3:0] exp_strb;
        logic       err;
        exp_strb = model_strobe(wr, size, addr[1:0]);
`ifdef AHB2APB_ERR_RESP_EN
        err = slverr;
`else
        err = 1'b0;
`endif
        // cycle 0: address phase
        check_eq("aph_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        check_eq("aph_psel", 32'(bus.PSEL), 32'd0);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'($urandom_range(2, 3));
        bus.HREADY = 1'b1;
        bus.HADDR  = addr;
        bus.HWRITE = wr;
        bus.HSIZE  = size;
        // cycle 1: LATCH
        @(negedge HCLK);
        check_eq("latch_hreadyout", 32'(bus.HREADYOUT), 32'd0);
        check_eq("latch_psel", 32'(bus.PSEL), 32'd0);
        drive_ahb_noise();
        bus.HWDATA = wdata;
        // cycle 2: SETUP
        @(negedge HCLK);
        check_eq("setup_psel", 32'(bus.PSEL), 32'd1);
        check_eq("setup_penable", 32'(bus.PENABLE), 32'd0);
        check_eq("setup_paddr", bus.PADDR, addr);
        check_eq("setup_pwrite", 32'(bus.PWRITE), 32'(wr));
        check_eq("setup_pstrb", 32'(bus.PSTRB), 32'(exp_strb));
        if (wr) check_eq("setup_pwdata", bus.PWDATA, wdata);
        check_eq("setup_hreadyout", 32'(bus.HREADYOUT), 32'd0);
        drive_ahb_noise();
        bus.HWDATA  = $urandom;
        bus.PREADY  = 1'($urandom);
        bus.PSLVERR = 1'($urandom);
        bus.PRDATA  = $urandom;
        // cycles 3 .. 3+waits: ACCESS
        for (int i = 0; i <= waits; i++) begin
            @(negedge HCLK);
            check_eq("access_psel", 32'(bus.PSEL), 32'd1);
            check_eq("access_penable", 32'(bus.PENABLE), 32'd1);
            check_eq("access_paddr", bus.PADDR, addr);
            check_eq("access_pwrite", 32'(bus.PWRITE), 32'(wr));
            check_eq("access_pstrb", 32'(bus.PSTRB), 32'(exp_strb));
            if (wr) check_eq("access_pwdata", bus.PWDATA, wdata);
            check_eq("access_hreadyout", 32'(bus.HREADYOUT), 32'd0);
            check_eq("access_hrdata", bus.HRDATA, exp_hrdata);
            drive_ahb_noise();
            bus.PREADY  = (i == waits);
            bus.PRDATA  = (i == waits) ? rdata : $urandom;
            bus.PSLVERR = (i == waits) ? slverr : 1'($urandom);
        end
        // cycle 4+waits: completion (or ERR1)
        @(negedge HCLK);
        bus.PREADY = 1'b0;
        clear_ahb();
        check_eq("done_psel", 32'(bus.PSEL), 32'd0);
        check_eq("done_penable", 32'(bus.PENABLE), 32'd0);
        if (err) begin
            check_eq("err1_hresp", 32'(bus.HRESP), 32'd1);
            check_eq("err1_hreadyout", 32'(bus.HREADYOUT), 32'd0);
            check_eq("err1_hrdata", bus.HRDATA, exp_hrdata);
            @(negedge HCLK);
            check_eq("err2_hresp", 32'(bus.HRESP), 32'd1);
            check_eq("err2_hreadyout", 32'(bus.HREADYOUT), 32'd1);
            // A transfer offered during ERR2 must be dropped.
            bus.HSEL   = 1'b1;
            bus.HTRANS = 2'b10;
            bus.HREADY = 1'b1;
            bus.HADDR  = $urandom;
            @(negedge HCLK);
            clear_ahb();
            check_eq("post_err_hresp", 32'(bus.HRESP), 32'd0);
            check_eq("post_err_hreadyout", 32'(bus.HREADYOUT), 32'd1);
            check_eq("post_err_psel", 32'(bus.PSEL), 32'd0);
            check_eq("post_err_hrdata", bus.HRDATA, exp_hrdata);
        end else begin
            if (!wr) exp_hrdata = rdata;
            check_eq("done_hreadyout", 32'(bus.HREADYOUT), 32'd1);
            check_eq("done_hresp", 32'(bus.HRESP), 32'd0);
            check_eq("done_hrdata", bus.HRDATA, exp_hrdata);
        end
    endtask

    // Cycles that must not start a transfer: unselected, IDLE/BUSY, or HREADY low.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 2))
                0: begin bus.HSEL = 1'b0; bus.HTRANS = 2'($urandom); bus.HREADY = 1'b1; end
                1: begin bus.HSEL = 1'b1; bus.HTRANS = 2'($urandom_range(0, 1)); bus.HREADY = 1'b1; end
                default: begin bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HREADY = 1'b0; end
            endcase
            bus.HADDR  = $urandom;
            bus.HWRITE = 1'($urandom);
            @(negedge HCLK);
            check_eq("idle_hreadyout", 32'(bus.HREADYOUT), 32'd1);
            check_eq("idle_hresp", 32'(bus.HRESP), 32'd0);
            check_eq("idle_psel", 32'(bus.PSEL), 32'd0);
            check_eq("idle_penable", 32'(bus.PENABLE), 32'd0);
            check_eq("idle_hrdata", bus.HRDATA, exp_hrdata);
        end
        clear_ahb();
    endtask

    // BUSY, then a read whose ACCESS is hit by an asynchronous reset.
    task automatic reset_mid_access();
        bus.HSEL = 1'b1; bus.HTRANS = 2'b01; bus.HREADY = 1'b1; bus.HADDR = 32'h40;
        @(negedge HCLK);
        check_eq("busy_psel", 32'(bus.PSEL), 32'd0);
        check_eq("busy_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HSIZE = 3'd2;
        @(negedge HCLK);
        drive_ahb_noise();
        bus.PREADY = 1'b0;
        @(negedge HCLK);
        drive_ahb_noise();
        @(negedge HCLK);
        check_eq("rst_pre_penable", 32'(bus.PENABLE), 32'd1);
        // NONSEQ offered during ACCESS, then reset mid-cycle.
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HREADY = 1'b1;
        #2 HRESET = 1'b1;
        #1;
        check_reset_vals("rst_async");
        exp_hrdata = 32'd0;
        bus.PREADY = 1'b1;
        bus.PRDATA = 32'hA5A5_5A5A;
        clear_ahb();
        @(negedge HCLK);
        @(negedge HCLK);
        check_reset_vals("rst_held");
        HRESET = 1'b0;
        idle_cycles(3);
        bus.PREADY = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        exp_hrdata = 32'd0;
        HRESET = 1'b1;
        bus.HSEL = 1'b0; bus.HADDR = 32'd0; bus.HWRITE = 1'b0; bus.HTRANS = 2'b00;
        bus.HSIZE = 3'd0; bus.HWDATA = 32'd0; bus.HREADY = 1'b1;
        bus.PRDATA = 32'd0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
        repeat (2) @(negedge HCLK);
        check_reset_vals("reset");
        HRESET = 1'b0;

        // Accepted on the first edge after reset release; word write.
        run_xfer(1'b1, 32'h0000_1004, 3'd2, 32'hDEAD_BEEF, 0, 32'd0, 1'b0);
        // Read with two PREADY-low ACCESS cycles, back to back.
        run_xfer(1'b0, 32'h0000_0020, 3'd2, 32'd0, 2, 32'h1234_5678, 1'b0);
        // Byte write at ...3 then halfword write at ...2.
        run_xfer(1'b1, 32'h0000_0103, 3'd0, 32'h1122_3344, 0, 32'd0, 1'b0);
        run_xfer(1'b1, 32'h0000_0102, 3'd1, 32'h5566_7788, 1, 32'd0, 1'b0);
        // Slave error on a write and on a read.
        run_xfer(1'b1, 32'h0000_0200, 3'd2, 32'h0BAD_F00D, 1, 32'd0, 1'b1);
        run_xfer(1'b0, 32'h0000_0204, 3'd2, 32'd0, 0, 32'hCAFE_F00D, 1'b1);
        idle_cycles(6);
        reset_mid_access();

        for (int t = 0; t < 60; t++) begin
            run_xfer(1'($urandom), $urandom, 3'($urandom_range(0, 3)), $urandom,
                     int'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
